// File: rtl/hs_sink_pkg.sv
// Shared types for the handshake sink: FSM state encoding and the width of
// the source-index field stored alongside each captured data word.
package hs_sink_pkg;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        WRITE,
        ACK
    } hs_sink_state_t;

    localparam int SRC_W = 1;

endpackage

// File: rtl/sink_fifo_mem.sv
// Register-array FIFO: push/pop with occupancy count and a combinational head.
// Push is refused when full unless a pop frees a slot in the same cycle.
module sink_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is deliberately left unreset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/handshake_sink_fifo.sv
// Clocked sink for a 4-phase req/ack arbiter: synchronizes req, captures the
// granted source's bundled data into a FIFO and drains it over valid/ready.
module handshake_sink_fifo
    import hs_sink_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    input  logic                         sel_in,
    input  logic [DATA_W-1:0]            data0_in,
    input  logic [DATA_W-1:0]            data1_in,
    output logic                         ack_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_src,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int WORD_W = DATA_W + SRC_W;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SW     = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLED    = SW'(SYNC_STAGES);

    hs_sink_state_t          state;
    hs_sink_state_t          state_next;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    req_s;
    logic [SW-1:0]           settle_cnt;
    logic                    settled;
    logic                    push;
    logic                    pop;
    logic [WORD_W-1:0]       push_word;
    logic [WORD_W-1:0]       head;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // The cleared synchronizer reads 0 regardless of req_in, so RESYNC must not
    // trust req_s until the chain has refilled with real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLED) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign settled = (settle_cnt == SETTLED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RESYNC: if (settled && !req_s)           state_next = IDLE;
            IDLE:   if (req_s && count < FULL_COUNT) state_next = WRITE;
            WRITE:                                   state_next = ACK;
            ACK:    if (!req_s)                      state_next = IDLE;
            default:                                 state_next = RESYNC;
        endcase
    end

    assign ack_out   = (state == ACK);
    assign push      = (state == WRITE);
    assign push_word = {sel_in, sel_in ? data1_in : data0_in};
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    sink_fifo_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign {out_src, out_data} = out_valid ? head : '0;

endmodule

// File: tb/tb_handshake_sink_fifo.sv
// Directed bench for handshake_sink_fifo: drives the arbiter side 4-phase and
// checks the drained words against a scoreboard queue filled at request time.
module tb_handshake_sink_fifo;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_in;
    logic              sel_in;
    logic [DATA_W-1:0] data0_in;
    logic [DATA_W-1:0] data1_in;
    logic              ack_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic [2:0]        count;

    int compared   = 0;
    int mismatched = 0;
    logic [8:0] sb[$];

    handshake_sink_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .sel_in    (sel_in),
        .data0_in  (data0_in),
        .data1_in  (data1_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raise a request with the selected source's word; the other source carries a decoy.
    task automatic applyStimulus(input logic sel, input logic [7:0] data);
        sel_in   = sel;
        data0_in = sel ? 8'hEE : data;
        data1_in = sel ? data : 8'hEE;
        req_in   = 1'b1;
        sb.push_back({sel, data});
    endtask

    task automatic waitAck(input string tag, input logic level, input int budget,
                           output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ack_out === level) break;
        end
        checkOutput(tag, 32'(ack_out), 32'(level));
    endtask

    task automatic dropReq();
        int c;
        req_in = 1'b0;
        waitAck("ack_release", 1'b0, 12, c);
    endtask

    // Called at a negedge with out_ready high: the head must match the oldest expected word.
    task automatic popHead(input string tag);
        logic [8:0] exp_word;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'(out_valid), 32'd0);
        end else begin
            exp_word = sb.pop_front();
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_word"}, {23'd0, out_src, out_data}, {23'd0, exp_word});
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; req_in = 1'b0; sel_in = 1'b0;
        data0_in = '0; data1_in = '0; out_ready = 1'b0;

        // 1: reset values and RESYNC -> IDLE with req low
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 32'(ack_out), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle_ack", 32'(ack_out), 32'd0);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_count", 32'(count), 32'd0);
        checkOutput("idle_data", {23'd0, out_src, out_data}, 32'd0);

        // 2: single capture from source 1 with exact latency
        applyStimulus(1'b1, 8'hA5);
        waitAck("ack_rise", 1'b1, 12, cyc);
        checkOutput("ack_latency", 32'(cyc), 32'(SYNC_STAGES + 2));
        checkOutput("t2_count", 32'(count), 32'd1);
        dropReq();
        out_ready = 1'b1;
        popHead("t2_pop");
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("t2_empty", 32'(count), 32'd0);

        // 3: fill to full, fifth request back-pressured until one pop
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'(i % 2 == 0), 8'(i));
            waitAck("fill_ack", 1'b1, 12, cyc);
            dropReq();
        end
        checkOutput("full_count", 32'(count), 32'd4);
        applyStimulus(1'b0, 8'h05);
        repeat (8) @(negedge clk);
        checkOutput("full_no_ack", 32'(ack_out), 32'd0);
        checkOutput("full_hold", 32'(count), 32'd4);
        out_ready = 1'b1;
        popHead("t3_pop1");
        @(negedge clk);
        out_ready = 1'b0;
        waitAck("fifth_ack", 1'b1, 12, cyc);
        checkOutput("refill_count", 32'(count), 32'd4);
        dropReq();

        // 4: drain while a blocked request is written in the same cycle as a pop
        applyStimulus(1'b1, 8'h06);
        repeat (8) @(negedge clk);
        checkOutput("t4_blocked", 32'(ack_out), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            popHead("t4_pop");
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("t4_count", 32'(count), 32'd2);
        checkOutput("t4_ack", 32'(ack_out), 32'd1);
        dropReq();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            popHead("t4_drain");
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("t4_empty", 32'(out_valid), 32'd0);

        // 5: reset in ACK with req still high; it must be ignored until it falls
        applyStimulus(1'b1, 8'h3C);
        waitAck("t5_ack", 1'b1, 12, cyc);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_ack", 32'(ack_out), 32'd0);
        checkOutput("t5_rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (10) @(negedge clk);
        checkOutput("t5_ignored_ack", 32'(ack_out), 32'd0);
        checkOutput("t5_ignored_count", 32'(count), 32'd0);
        req_in = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(1'b0, 8'h5A);
        waitAck("t5_resume_ack", 1'b1, 12, cyc);
        checkOutput("t5_resume_count", 32'(count), 32'd1);
        dropReq();
        out_ready = 1'b1;
        popHead("t5_pop");
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("t5_final_empty", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
